// File: rtl/framebuffer_dp.sv
// Dual-port pixel frame buffer: host write port, registered scan read port,
// a hardware clear engine, out-of-range checks and frame/drop status flags.
module framebuffer_dp #(
    parameter int               H_RES       = 640,
    parameter int               V_RES       = 480,
    parameter int               PIX_W       = 12,
    parameter int               ADDR_W      = 19,
    parameter logic [PIX_W-1:0] CLEAR_COLOR = '0
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_adr_i,
    input  logic [PIX_W-1:0]  wr_dat_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] rd_adr_i,
    output logic [PIX_W-1:0]  rd_dat_o,
    output logic              rd_valid_o,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              fin,
    output logic              wr_drop_o
);
    localparam int                DEPTH = H_RES * V_RES;
    localparam int                IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              fin_q, fin_d;
    logic              drop_q, drop_d;
    logic [PIX_W-1:0]  rd_dat_q;
    logic              rd_valid_q;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [PIX_W-1:0]  mem_wd;
    logic              rd_in_rng;

    logic [PIX_W-1:0]  mem [DEPTH];

    assign rd_in_rng = (rd_adr_i <= LAST);

    // Single write port shared by host and clear engine; the engine owns it while clearing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        drop_d  = drop_q;
        mem_we  = 1'b0;
        mem_idx = wr_adr_i[IDX_W-1:0];
        mem_wd  = wr_dat_i;
        case (state_q)
            IDLE: begin
                if (we_i) begin
                    if (wr_adr_i <= LAST) begin
                        mem_we = 1'b1;
                        if (wr_adr_i == LAST) fin_d = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                // A same-cycle host write still lands; the clear then overwrites it.
                if (clear_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    fin_d   = 1'b0;
                    drop_d  = 1'b0;
                end
            end
            CLEAR: begin
                mem_we  = 1'b1;
                mem_idx = cnt_q[IDX_W-1:0];
                mem_wd  = CLEAR_COLOR;
                if (we_i) drop_d = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            drop_q  <= drop_d;
        end
    end

    // RAM contents are never reset; reset only suppresses the write on that edge.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst) mem[mem_idx] <= mem_wd;
    end

    // Read-first: nonblocking write above means the old word is captured here.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            rd_dat_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= re_i;
            if (re_i) rd_dat_q <= rd_in_rng ? mem[rd_adr_i[IDX_W-1:0]] : '0;
        end
    end

    assign rd_dat_o   = rd_dat_q;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = (state_q == CLEAR);
    assign fin        = fin_q;
    assign wr_drop_o  = drop_q;
endmodule

// File: tb/tb_framebuffer_dp.sv
// Directed bench for framebuffer_dp on a reduced 8x4 frame (DEPTH=32, last address 31).
module tb_framebuffer_dp;
    localparam int ADDR_W = 6;
    localparam int PIX_W  = 12;

    logic              clk_i = 1'b0;
    logic              rst = 1'b0;
    logic              we_i = 1'b0;
    logic [ADDR_W-1:0] wr_adr_i = '0;
    logic [PIX_W-1:0]  wr_dat_i = '0;
    logic              re_i = 1'b0;
    logic [ADDR_W-1:0] rd_adr_i = '0;
    logic [PIX_W-1:0]  rd_dat_o;
    logic              rd_valid_o;
    logic              clear_i = 1'b0;
    logic              busy_o;
    logic              fin;
    logic              wr_drop_o;

    int n_cmp = 0;
    int n_err = 0;

    framebuffer_dp #(
        .H_RES(8), .V_RES(4), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .CLEAR_COLOR(12'h000)
    ) dut (
        .clk_i(clk_i), .rst(rst), .we_i(we_i), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i),
        .re_i(re_i), .rd_adr_i(rd_adr_i), .rd_dat_o(rd_dat_o), .rd_valid_o(rd_valid_o),
        .clear_i(clear_i), .busy_o(busy_o), .fin(fin), .wr_drop_o(wr_drop_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] d);
        we_i = 1'b1; wr_adr_i = a; wr_dat_i = d;
        tick();
        we_i = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] exp);
        re_i = 1'b1; rd_adr_i = a;
        tick();
        re_i = 1'b0;
        chk(tag, {20'h0, rd_dat_o}, {20'h0, exp});
        chk({tag, "_vld"}, {31'h0, rd_valid_o}, 32'd1);
    endtask

    initial begin
        int busy_cnt;

        // 1: reset values, basic write/read latency and hold
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        chk("rst_rd_dat", {20'h0, rd_dat_o}, 32'h0);
        chk("rst_rd_vld", {31'h0, rd_valid_o}, 32'd0);
        chk("rst_busy", {31'h0, busy_o}, 32'd0);
        chk("rst_fin", {31'h0, fin}, 32'd0);
        chk("rst_drop", {31'h0, wr_drop_o}, 32'd0);
        wr(6'd0, 12'hABC);
        rd_chk("rd0", 6'd0, 12'hABC);
        tick();
        chk("idle_vld", {31'h0, rd_valid_o}, 32'd0);
        chk("hold_dat", {20'h0, rd_dat_o}, 32'hABC);

        // 2: read-first on a same-address collision
        wr(6'd5, 12'h0F0);
        we_i = 1'b1; wr_adr_i = 6'd5; wr_dat_i = 12'h123;
        re_i = 1'b1; rd_adr_i = 6'd5;
        tick();
        we_i = 1'b0; re_i = 1'b0;
        chk("rf_old", {20'h0, rd_dat_o}, 32'h0F0);
        rd_chk("rf_new", 6'd5, 12'h123);

        // 3: sequential fill; fin rises only on the write to the last address
        for (int i = 0; i < 32; i++) begin
            wr(ADDR_W'(i), PIX_W'(12'h100 + i));
            chk($sformatf("fin_%0d", i), {31'h0, fin}, (i == 31) ? 32'd1 : 32'd0);
        end
        rd_chk("fill7", 6'd7, 12'h107);
        rd_chk("fill31", 6'd31, 12'h11F);
        rd_chk("oob_rd", 6'd40, 12'h000);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("fin_rst", {31'h0, fin}, 32'd0);

        // 4: out-of-range write dropped, memory untouched
        wr(6'd32, 12'hFFF);
        chk("drop_oob", {31'h0, wr_drop_o}, 32'd1);
        rd_chk("oob_nowr0", 6'd0, 12'h100);
        chk("fin_oob", {31'h0, fin}, 32'd0);

        // 5: clear with a same-cycle host write; clear_i/we_i during clear
        wr(6'd31, 12'h1FF);
        chk("fin_pre_clr", {31'h0, fin}, 32'd1);
        we_i = 1'b1; wr_adr_i = 6'd3; wr_dat_i = 12'h333; clear_i = 1'b1;
        tick();
        we_i = 1'b0; clear_i = 1'b0;
        chk("clr_busy", {31'h0, busy_o}, 32'd1);
        chk("clr_drop0", {31'h0, wr_drop_o}, 32'd0);
        chk("clr_fin0", {31'h0, fin}, 32'd0);
        busy_cnt = 1;
        for (int k = 0; k < 100 && busy_o; k++) begin
            we_i    = (k == 5);
            wr_adr_i = 6'd2; wr_dat_i = 12'h555;
            clear_i = (k == 8);
            tick();
            if (busy_o) busy_cnt++;
        end
        we_i = 1'b0; clear_i = 1'b0;
        chk("busy_len", busy_cnt, 32'd32);
        chk("busy_end", {31'h0, busy_o}, 32'd0);
        chk("drop_mid", {31'h0, wr_drop_o}, 32'd1);
        chk("fin_after", {31'h0, fin}, 32'd0);
        rd_chk("clr0", 6'd0, 12'h000);
        rd_chk("clr2", 6'd2, 12'h000);
        rd_chk("clr3", 6'd3, 12'h000);
        rd_chk("clr31", 6'd31, 12'h000);

        // 6: reset part-way through a clear aborts it
        for (int i = 0; i < 32; i++) wr(ADDR_W'(i), PIX_W'(12'h200 + i));
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_busy", {31'h0, busy_o}, 32'd0);
        chk("abort_fin", {31'h0, fin}, 32'd0);
        rd_chk("abort0", 6'd0, 12'h000);
        rd_chk("abort9", 6'd9, 12'h000);
        rd_chk("abort10", 6'd10, 12'h20A);
        rd_chk("abort31", 6'd31, 12'h21F);
        tick();
        chk("abort_idle", {31'h0, busy_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
